// File: rtl/seq_div.sv
// Iterative non-restoring divider: one quotient bit per clock, unsigned or
// two's-complement signed, with divide-by-zero/overflow flags and a start/busy/done handshake.
module seq_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             dz,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                  st, nxt;
  logic signed [WIDTH:0]   a, a_sh, a_nx, dext;
  logic        [WIDTH-1:0] q, d, r_mag;
  logic        [CW-1:0]    cnt;
  logic                    neg_q, neg_r, ovf_pend;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // A is one bit wider than the operands so an unsigned divisor near 2^WIDTH keeps its carry
  assign dext  = $signed({1'b0, d});
  assign a_sh  = $signed({a[WIDTH-1:0], q[WIDTH-1]});
  assign a_nx  = a[WIDTH] ? (a_sh + dext) : (a_sh - dext);
  assign r_mag = a[WIDTH] ? WIDTH'(a + dext) : a[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= nxt;
  end

  always_comb begin
    nxt = st;
    case (st)
      IDLE:    if (start) nxt = (den == '0) ? DONE : CALC;
      CALC:    if (cnt == CW'(1)) nxt = FIX;
      FIX:     nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (st == CALC) || (st == FIX);
    done = (st == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a        <= '0;
      q        <= '0;
      d        <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ovf_pend <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      dz       <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (st)
        IDLE: if (start) begin
          if (den == '0) begin
            quo <= '1;
            rem <= num;
            dz  <= 1'b1;
            ovf <= 1'b0;
          end else begin
            a        <= '0;
            q        <= mag(num, sgn);
            d        <= mag(den, sgn);
            cnt      <= CW'(WIDTH);
            neg_q    <= sgn & (num[WIDTH-1] ^ den[WIDTH-1]);
            neg_r    <= sgn & num[WIDTH-1];
            ovf_pend <= sgn && (num == MIN) && (den == '1);
            dz       <= 1'b0;
            ovf      <= 1'b0;
          end
        end
        CALC: begin
          a   <= a_nx;
          q   <= {q[WIDTH-2:0], ~a_nx[WIDTH]};
          cnt <= cnt - CW'(1);
        end
        // MIN / -1 needs no special path: |MIN| / 1 wraps back to MIN on its own
        FIX: begin
          quo <= apply_sign(q, neg_q);
          rem <= apply_sign(r_mag, neg_r);
          ovf <= ovf_pend;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: a WIDTH=8 lane with directed vectors and a WIDTH=16 lane with an
// unsigned random sweep, both checked every cycle against an integer-arithmetic model.
module tb_seq_div;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0]       start_a, sgn_a;
  logic [1:0][15:0] num_a, den_a, quo_a, rem_a;
  logic [1:0]       busy_a, done_a, dz_a, ovf_a;

  logic [7:0]  quo8, rem8;
  logic [15:0] quo16, rem16;
  logic        busy8, done8, dz8, ovf8, busy16, done16, dz16, ovf16;

  int tests = 0;
  int fails = 0;

  // model state per lane
  int          m_cyc[2] = '{0, 0};
  int          m_lat[2] = '{1, 1};
  logic        m_valid[2] = '{1'b0, 1'b0};
  logic [15:0] m_quo[2], m_rem[2];
  logic        m_dz[2], m_ovf[2];

  seq_div #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .sgn(sgn_a[0]),
    .num(num_a[0][7:0]), .den(den_a[0][7:0]),
    .busy(busy8), .done(done8), .quo(quo8), .rem(rem8), .dz(dz8), .ovf(ovf8)
  );

  seq_div #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .sgn(sgn_a[1]),
    .num(num_a[1]), .den(den_a[1]),
    .busy(busy16), .done(done16), .quo(quo16), .rem(rem16), .dz(dz16), .ovf(ovf16)
  );

  assign quo_a  = {quo16, 8'h00, quo8};
  assign rem_a  = {rem16, 8'h00, rem8};
  assign busy_a = {busy16, busy8};
  assign done_a = {done16, done8};
  assign dz_a   = {dz16, dz8};
  assign ovf_a  = {ovf16, ovf8};

  initial forever #5 clk = ~clk;

  function automatic int lw(input int k);
    return (k == 0) ? 8 : 16;
  endfunction

  // Division result from the arithmetic definition, not from any shift/subtract scheme
  function automatic void model(input int w, input logic s, input logic [15:0] n_in,
                                input logic [15:0] d_in, output logic [15:0] eq,
                                output logic [15:0] er, output logic edz, output logic eovf);
    longint m, n, d, sn, sd;
    m    = (longint'(1) << w) - 1;
    n    = longint'(n_in) & m;
    d    = longint'(d_in) & m;
    edz  = 1'b0;
    eovf = 1'b0;
    if (d == 0) begin
      eq  = 16'(m);
      er  = 16'(n);
      edz = 1'b1;
    end else if (!s) begin
      eq = 16'(n / d);
      er = 16'(n % d);
    end else begin
      sn = n[w-1] ? n - (longint'(1) << w) : n;
      sd = d[w-1] ? d - (longint'(1) << w) : d;
      if (sn == -(longint'(1) << (w-1)) && sd == -1) begin
        eq   = 16'(n);
        er   = 16'h0;
        eovf = 1'b1;
      end else begin
        eq = 16'((sn / sd) & m);
        er = 16'((sn % sd) & m);
      end
    end
  endfunction

  task automatic chk(input int k, input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL lane%0d %s: got %0h expected %0h at %0t", k, nm, act, exp, $time);
    end
  endtask

  // Model: tracks acceptance and cycle position of the outstanding operation per lane
  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_cyc[k]   = 0;
        m_valid[k] = 1'b0;
      end else if (m_cyc[k] == 0) begin
        if (start_a[k]) begin
          model(lw(k), sgn_a[k], num_a[k], den_a[k], m_quo[k], m_rem[k], m_dz[k], m_ovf[k]);
          m_lat[k]   = m_dz[k] ? 1 : lw(k) + 2;
          m_cyc[k]   = 1;
          m_valid[k] = 1'b0;
        end
      end else if (m_cyc[k] == m_lat[k]) begin
        m_cyc[k]   = 0;
        m_valid[k] = 1'b1;
      end else begin
        m_cyc[k]++;
      end
    end
  end

  // Compare: every negedge, every lane
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        chk(k, "rst_busy", busy_a[k], 1'b0);
        chk(k, "rst_done", done_a[k], 1'b0);
        chk(k, "rst_quo", quo_a[k], 16'h0);
        chk(k, "rst_rem", rem_a[k], 16'h0);
      end else begin
        chk(k, "busy", busy_a[k], (m_cyc[k] != 0) && (m_cyc[k] < m_lat[k]));
        chk(k, "done", done_a[k], (m_cyc[k] != 0) && (m_cyc[k] == m_lat[k]));
        if (((m_cyc[k] != 0) && (m_cyc[k] == m_lat[k])) || (m_cyc[k] == 0 && m_valid[k])) begin
          chk(k, "quo", quo_a[k], m_quo[k]);
          chk(k, "rem", rem_a[k], m_rem[k]);
          chk(k, "dz", dz_a[k], m_dz[k]);
          chk(k, "ovf", ovf_a[k], m_ovf[k]);
        end
      end
    end
  end

  task automatic launch(input int k, input logic s, input logic [15:0] n, input logic [15:0] d);
    @(negedge clk); #1;
    start_a[k] = 1'b1;
    sgn_a[k]   = s;
    num_a[k]   = n;
    den_a[k]   = d;
    @(negedge clk); #1;
    start_a[k] = 1'b0;
    num_a[k]   = 16'($urandom);
    den_a[k]   = 16'($urandom);
  endtask

  task automatic wait_done(input int k, output int cyc, output int bcyc, output logic [15:0] rq,
                           output logic [15:0] rr, output logic rdz, output logic rovf);
    cyc  = 1;
    bcyc = 0;
    while (!done_a[k] && cyc < 60) begin
      if (busy_a[k]) bcyc++;
      @(negedge clk); #1;
      cyc++;
    end
    chk(k, "done_seen", done_a[k], 1'b1);
    rq   = quo_a[k];
    rr   = rem_a[k];
    rdz  = dz_a[k];
    rovf = ovf_a[k];
  endtask

  task automatic run_chk(input int k, input logic s, input logic [15:0] n, input logic [15:0] d,
                         input logic [15:0] eq, input logic [15:0] er, input logic edz,
                         input logic eovf, input int elat, input int ebusy);
    int cyc, bcyc;
    logic [15:0] rq, rr;
    logic rdz, rovf;
    launch(k, s, n, d);
    wait_done(k, cyc, bcyc, rq, rr, rdz, rovf);
    chk(k, "d_quo", rq, eq);
    chk(k, "d_rem", rr, er);
    chk(k, "d_dz", rdz, edz);
    chk(k, "d_ovf", rovf, eovf);
    chk(k, "d_latency", cyc, elat);
    chk(k, "d_busy_cycles", bcyc, ebusy);
  endtask

  initial begin
    int cyc, bcyc;
    logic [15:0] rq, rr, eq, er, n, d;
    logic rdz, rovf, edz, eovf;
    rst_n = 1'b1; start_a = '0; sgn_a = '0; num_a = '0; den_a = '0;
    #2 rst_n = 1'b0;
    @(negedge clk); #1;
    chk(0, "reset_busy", busy_a[0], 1'b0);
    chk(0, "reset_done", done_a[0], 1'b0);
    chk(0, "reset_quo", quo_a[0], 16'h0);
    chk(0, "reset_rem", rem_a[0], 16'h0);
    chk(0, "reset_dz", dz_a[0], 1'b0);
    chk(0, "reset_ovf", ovf_a[0], 1'b0);

    // pin the model itself with hand-computed results
    model(8, 1'b0, 16'd200, 16'd7, eq, er, edz, eovf);
    chk(0, "pin_u_quo", eq, 16'h1C); chk(0, "pin_u_rem", er, 16'h04);
    model(8, 1'b1, 16'h9C, 16'h07, eq, er, edz, eovf);
    chk(0, "pin_s_quo", eq, 16'hF2); chk(0, "pin_s_rem", er, 16'hFE);
    model(8, 1'b1, 16'h80, 16'hFF, eq, er, edz, eovf);
    chk(0, "pin_ovf_quo", eq, 16'h80); chk(0, "pin_ovf_flag", eovf, 1'b1);
    model(8, 1'b0, 16'h55, 16'h00, eq, er, edz, eovf);
    chk(0, "pin_dz_quo", eq, 16'hFF); chk(0, "pin_dz_flag", edz, 1'b1);

    @(negedge clk); #2 rst_n = 1'b1;

    run_chk(0, 1'b0, 16'hC8, 16'h07, 16'h1C, 16'h04, 1'b0, 1'b0, 10, 9);
    run_chk(0, 1'b1, 16'h9C, 16'h07, 16'hF2, 16'hFE, 1'b0, 1'b0, 10, 9);
    run_chk(0, 1'b1, 16'h64, 16'hF9, 16'hF2, 16'h02, 1'b0, 1'b0, 10, 9);
    run_chk(0, 1'b1, 16'h80, 16'hFF, 16'h80, 16'h00, 1'b0, 1'b1, 10, 9);
    run_chk(0, 1'b0, 16'h80, 16'hFF, 16'h00, 16'h80, 1'b0, 1'b0, 10, 9);
    run_chk(0, 1'b0, 16'h55, 16'h00, 16'hFF, 16'h55, 1'b1, 1'b0, 1, 0);
    run_chk(0, 1'b1, 16'h55, 16'h00, 16'hFF, 16'h55, 1'b1, 1'b0, 1, 0);

    // second start during CALC must be dropped
    launch(0, 1'b0, 16'hF0, 16'h0D);
    @(negedge clk); @(negedge clk); #1;
    start_a[0] = 1'b1; num_a[0] = 16'h11; den_a[0] = 16'h01;
    @(negedge clk); #1;
    start_a[0] = 1'b0;
    wait_done(0, cyc, bcyc, rq, rr, rdz, rovf);
    chk(0, "ign_quo", rq, 16'h12);
    chk(0, "ign_rem", rr, 16'h06);
    repeat (4) @(negedge clk);
    #1;
    chk(0, "hold_quo", quo_a[0], 16'h12);
    chk(0, "hold_rem", rem_a[0], 16'h06);
    chk(0, "hold_done", done_a[0], 1'b0);

    // asynchronous abort in the middle of CALC
    launch(0, 1'b1, 16'h9C, 16'h07);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk(0, "abort_busy", busy_a[0], 1'b0);
    chk(0, "abort_done", done_a[0], 1'b0);
    chk(0, "abort_quo", quo_a[0], 16'h0);
    chk(0, "abort_rem", rem_a[0], 16'h0);
    chk(0, "abort_dz", dz_a[0], 1'b0);
    chk(0, "abort_ovf", ovf_a[0], 1'b0);
    @(negedge clk); @(negedge clk); #2 rst_n = 1'b1;
    run_chk(0, 1'b1, 16'h9C, 16'h07, 16'hF2, 16'hFE, 1'b0, 1'b0, 10, 9);

    // WIDTH=16 lane
    run_chk(1, 1'b0, 16'd50000, 16'd7, 16'h1BE6, 16'h0006, 1'b0, 1'b0, 18, 17);
    run_chk(1, 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1, 0);
    for (int i = 0; i < 24; i++) begin
      n = 16'($urandom_range(0, 65535));
      d = (i % 6 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom_range(1, 65535));
      launch(1, 1'b0, n, d);
      wait_done(1, cyc, bcyc, rq, rr, rdz, rovf);
      chk(1, "sweep_latency", cyc, (d == 16'h0) ? 1 : 18);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
